jmp_snoop: RTL
==============

// Module: jmp_snoop
// PURPOSE
// - Passive bus decoder for the 8080 read stream; the receiving end of the JMP boot-injection sequence.
// - Watches CPU read strobes and data, and recognises a 3-byte JMP (C3 lo hi).
//   With MATCH_CALL set, it also recognises CALL (CD lo hi).
// - Reports the 16-bit target. Latches the first target seen after reset, for boot-vector checking and debug.
// PARAMETERS
// - MATCH_CALL   0    1: opcode CD is accepted as well as C3
// - TIMEOUT      255  clk cycles allowed between operand read edges before abort (1..65535)
// - CNT_W        8    width of jmp_count
// PORTS
// - clk          in   1      system clock
// - reset        in   1      synchronous, active-high reset
// - en           in   1      1: decode enabled; 0: held in IDLE
// - rd           in   1      CPU read strobe, level
// - sync         in   1      1 during an opcode-fetch read (M1), 0 during operand reads
// - data_in      in   8      read data; valid while rd=1
// - target_addr  out  16     {hi,lo} of the last completed JMP/CALL
// - target_valid out  1      1-cycle pulse when target_addr updates
// - is_call      out  1      opcode of the last completed match was CD
// - aborted      out  1      1-cycle pulse when a partial sequence is dropped
// - first_addr   out  16     target of the first completed match since reset
// - first_seen   out  1      first_addr is valid (sticky until reset)
// - jmp_count    out  CNT_W  completed matches, saturating at all-ones
// - busy         out  1      state != IDLE
// BEHAVIOUR
// - Single clock domain. Reset is synchronous and active-high.
// - Reset values: all outputs 0; prev_rd=0; state=IDLE; timeout counter=0.
// - Edge detection:
//   - prev_rd is registered each cycle.
//   - ev = rd & ~prev_rd.
//   - data_in and sync are sampled in the ev cycle.
//   - Strobes held high produce exactly one ev.
// - States:
//   - IDLE: on ev & sync & opcode match -> LO. Store is_call_pending. Clear timer.
//   - LO:
//     - ev & ~sync: lo <= data_in -> HI. Clear timer.
//     - ev & sync: abort, then re-evaluate this byte as an opcode.
//       A match goes to LO; otherwise go to IDLE.
//   - HI:
//     - ev & ~sync: go to IDLE. Commit target_addr <= {data_in, lo} and is_call <= is_call_pending.
//       Assert target_valid the next cycle, i.e. the commit is registered with 1-cycle latency after ev.
//     - ev & sync: abort and re-evaluate, as in LO.
// - Timeout:
//   - In LO/HI, without ev, the timer increments.
//   - When timer == TIMEOUT-1: go to IDLE and pulse aborted. No target update.
//   - The timer does not count in IDLE.
// - Abort pulse: aborted goes high the cycle after the abort decision, for 1 cycle.
//   aborted and target_valid are never high together.
// - On the first commit after reset: first_addr <= target, first_seen <= 1. Later commits leave both unchanged.
// - jmp_count increments on each commit and saturates (no wrap).
// - en=0:
//   - State is forced to IDLE and the timer cleared.
//   - A partial sequence is dropped silently: no aborted pulse.
//   - prev_rd keeps tracking, so an rd held across en rising does not produce an ev.
// - target_addr holds its value between commits. Read data outside a match is ignored.
// - Reset asserted mid-sequence: the sequence is discarded and no pulses are generated.
// - Latency: target_valid rises 1 cycle after the ev of the hi byte.
// TESTING
// - reset; sync=1 ev C3; sync=0 ev 00; sync=0 ev FD -> target_valid 1 cycle, target_addr=FD00,
//   first_addr=FD00, first_seen=1, jmp_count=1.
// - MATCH_CALL=0: CD,34,12 -> no target_valid, count stays 0.
//   MATCH_CALL=1: CD,34,12 -> target=1234, is_call=1.
// - C3 then ev 10 (sync=0), then TIMEOUT cycles with no ev -> aborted pulse, busy=0, target unchanged.
// - C3, 00, then sync=1 ev C3, 00(sync=0), E0(sync=0) -> aborted once, then target=E000.
// - rd held high 10 cycles with data C3 -> only one ev; a second C3 is not seen as a new opcode.
// - Reset after C3,00 -> busy=0, all outputs 0. Then 300 C3,00,FD sequences -> jmp_count saturates at FF,
//   first_addr=FD00.

Source files
------------

// File: rtl/jmp_snoop.sv
// rtl/jmp_snoop.sv - passive 8080 read-stream decoder for JMP (and optionally CALL) targets
// Follows opcode/lo/hi read edges and reports the assembled 16-bit target.
module jmp_snoop #(
   parameter int MATCH_CALL = 0,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             rd,
   input  logic             sync,
   input  logic [7:0]       data_in,
   output logic [15:0]      target_addr,
   output logic             target_valid,
   output logic             is_call,
   output logic             aborted,
   output logic [15:0]      first_addr,
   output logic             first_seen,
   output logic [CNT_W-1:0] jmp_count,
   output logic             busy
);

   localparam logic [1:0]  S_IDLE       = 2'd0;
   localparam logic [1:0]  S_LO         = 2'd1;
   localparam logic [1:0]  S_HI         = 2'd2;
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
   localparam logic [7:0]  OP_JMP       = 8'hC3;
   localparam logic [7:0]  OP_CALL      = 8'hCD;

   logic [1:0]  state, state_nx;
   logic        prev_rd;
   logic [7:0]  lo_q, lo_nx;
   logic        pend_q, pend_nx;
   logic [15:0] timer, timer_nx;
   logic        ev;
   logic        is_cd;
   logic        op_hit;
   logic        commit;
   logic        abort;

   assign ev     = rd & ~prev_rd;
   assign is_cd  = (data_in == OP_CALL);
   assign op_hit = (data_in == OP_JMP) || ((MATCH_CALL != 0) && is_cd);
   assign busy   = (state != S_IDLE);

   always_comb begin
      state_nx = state;
      lo_nx    = lo_q;
      pend_nx  = pend_q;
      timer_nx = timer;
      commit   = 1'b0;
      abort    = 1'b0;
      if (!en) begin
         // disabling drops a partial sequence without an abort pulse
         state_nx = S_IDLE;
         timer_nx = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ev && sync && op_hit) begin
                  state_nx = S_LO;
                  pend_nx  = is_cd;
                  timer_nx = '0;
               end
            end
            S_LO, S_HI: begin
               if (ev && sync) begin
                  // a new M1 fetch kills the sequence but may itself start a new one
                  abort    = 1'b1;
                  timer_nx = '0;
                  if (op_hit) begin
                     state_nx = S_LO;
                     pend_nx  = is_cd;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end else if (ev) begin
                  timer_nx = '0;
                  if (state == S_LO) begin
                     lo_nx    = data_in;
                     state_nx = S_HI;
                  end else begin
                     commit   = 1'b1;
                     state_nx = S_IDLE;
                  end
               end else if (timer == TIMEOUT_LAST) begin
                  abort    = 1'b1;
                  timer_nx = '0;
                  state_nx = S_IDLE;
               end else begin
                  timer_nx = timer + 16'd1;
               end
            end
            default: begin
               state_nx = S_IDLE;
               timer_nx = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         prev_rd      <= 1'b0;
         lo_q         <= '0;
         pend_q       <= 1'b0;
         timer        <= '0;
         target_addr  <= '0;
         target_valid <= 1'b0;
         is_call      <= 1'b0;
         aborted      <= 1'b0;
         first_addr   <= '0;
         first_seen   <= 1'b0;
         jmp_count    <= '0;
      end else begin
         prev_rd      <= rd;
         state        <= state_nx;
         lo_q         <= lo_nx;
         pend_q       <= pend_nx;
         timer        <= timer_nx;
         target_valid <= commit;
         aborted      <= abort;
         if (commit) begin
            target_addr <= {data_in, lo_q};
            is_call     <= pend_q;
            if (jmp_count != {CNT_W{1'b1}}) begin
               jmp_count <= jmp_count + CNT_W'(1);
            end
            if (!first_seen) begin
               first_addr <= {data_in, lo_q};
               first_seen <= 1'b1;
            end
         end
      end
   end

endmodule
